// File: rtl/seq_stage_controller_pkg.sv
// -----------------------------------------------------------------------------
// seq_stage_controller_pkg
// Shared definitions for the SEQ stage controller: Y86-64 status codes,
// instruction codes, controller state encodings and a helper that classifies
// data-memory instructions.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds the PAUSE state encoding.
// -----------------------------------------------------------------------------
package seq_stage_controller_pkg;

    // Y86-64 status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Y86-64 instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_MEMORY    = 4'd4,
        ST_WRITEBACK = 4'd5,
        ST_PCUPD     = 4'd6,
`ifdef SEQ_SINGLE_STEP_EN
        ST_HALT      = 4'd7,
        ST_PAUSE     = 4'd8
`else
        ST_HALT      = 4'd7
`endif
    } ctrl_state_e;

    // Instructions that touch data memory and therefore need the handshake
    function automatic logic is_mem_icode(input logic [3:0] ic);
        logic mem_s;
        case (ic)
            I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: mem_s = 1'b1;
            default:                                            mem_s = 1'b0;
        endcase
        return mem_s;
    endfunction

endpackage

// File: rtl/seq_stage_controller_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_stage_controller_mem_wait_timer
// Counts cycles spent waiting in the MEMORY stage. The count restarts from 0
// whenever clear is high and saturates at MEM_TIMEOUT-1; expired flags that
// the current MEMORY cycle is the last one allowed.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         force count to 0 (controller not in MEMORY)
//   count_en      advance count (controller in MEMORY)
//   expired       count has reached MEM_TIMEOUT-1
// -----------------------------------------------------------------------------
module seq_stage_controller_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] count_r;

    // Wait counter: cleared outside MEMORY, holds at LAST so it cannot wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TW{1'b0}};
        end else if (clear) begin
            count_r <= {TW{1'b0}};
        end else if (count_en && (count_r != LAST)) begin
            count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/seq_stage_controller.sv
// -----------------------------------------------------------------------------
// seq_stage_controller
// Multi-cycle sequencer for the Y86-64 SEQ datapath. One stage enable per
// cycle (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD), data-memory
// request/ready handshake with timeout, Y86 status tracking and saturating
// cycle / retired-instruction counters. All outputs are registered.
// Optional feature macro: SEQ_SINGLE_STEP_EN -- adds input step and a PAUSE
// state entered after every PCUPD; step=1 in PAUSE resumes at FETCH.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   step (macro only)        single-step resume from PAUSE
//   start                    leave IDLE (ignored elsewhere)
//   icode, instr_valid,
//   imem_error               fetch-stage status
//   mem_ready, dmem_error    data-memory handshake (error qualified by ready)
//   *_en                     stage enables, one-hot or all zero
//   mem_req                  data-memory request
//   stat                     Y86 status (AOK/HLT/ADR/INS)
//   halted, busy             machine stopped / executing
//   cycle_count, instr_count saturating counters
// -----------------------------------------------------------------------------
module seq_stage_controller
    import seq_stage_controller_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_e state_r;
    ctrl_state_e nxt_state_s;
    logic [2:0]  nxt_stat_s;
    logic        retire_s;
    logic        nxt_mem_req_s;
    logic        nxt_busy_s;
    logic        in_mem_s;
    logic        tmr_expired_s;

    assign in_mem_s = (state_r == ST_MEMORY);

    seq_stage_controller_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!in_mem_s),
        .count_en (in_mem_s),
        .expired  (tmr_expired_s)
    );

    // Next-state, status update and retire decision for the current stage
    always_comb begin
        nxt_state_s = state_r;
        nxt_stat_s  = stat;
        retire_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    nxt_state_s = ST_FETCH;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_error) begin
                    nxt_stat_s  = STAT_ADR;
                    nxt_state_s = ST_HALT;
                end else if (!instr_valid) begin
                    nxt_stat_s  = STAT_INS;
                    nxt_state_s = ST_HALT;
                end else if (icode == I_HALT) begin
                    // halt retires: it counts as an executed instruction
                    nxt_stat_s  = STAT_HLT;
                    nxt_state_s = ST_HALT;
                    retire_s    = 1'b1;
                end else begin
                    nxt_state_s = ST_DECODE;
                end
            end
            ST_DECODE:  nxt_state_s = ST_EXECUTE;
            ST_EXECUTE: nxt_state_s = ST_MEMORY;
            ST_MEMORY: begin
                // mem_req marks a memory instruction; others pass in one cycle
                if (!mem_req) begin
                    nxt_state_s = ST_WRITEBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        nxt_stat_s  = STAT_ADR;
                        nxt_state_s = ST_HALT;
                    end else begin
                        nxt_state_s = ST_WRITEBACK;
                    end
                end else if (tmr_expired_s) begin
                    nxt_stat_s  = STAT_ADR;
                    nxt_state_s = ST_HALT;
                end else begin
                    nxt_state_s = ST_MEMORY;
                end
            end
            ST_WRITEBACK: nxt_state_s = ST_PCUPD;
            ST_PCUPD: begin
                retire_s = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                nxt_state_s = ST_PAUSE;
`else
                nxt_state_s = ST_FETCH;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    nxt_state_s = ST_FETCH;
                end else begin
                    nxt_state_s = ST_PAUSE;
                end
            end
`endif
            ST_HALT: nxt_state_s = ST_HALT;
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_stat_s  = STAT_AOK;
            end
        endcase
    end

    // Request decision: chosen on MEMORY entry from icode, then held while waiting
    always_comb begin
        nxt_mem_req_s = 1'b0;
        if (nxt_state_s == ST_MEMORY) begin
            if (state_r == ST_MEMORY) begin
                nxt_mem_req_s = mem_req;
            end else begin
                nxt_mem_req_s = is_mem_icode(icode);
            end
        end else begin
            nxt_mem_req_s = 1'b0;
        end
    end

    // Busy covers every state that is actively executing an instruction
    always_comb begin
        case (nxt_state_s)
            ST_IDLE, ST_HALT: nxt_busy_s = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
            ST_PAUSE:         nxt_busy_s = 1'b0;
`endif
            default:          nxt_busy_s = 1'b1;
        endcase
    end

    // Controller state, registered outputs and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            fetch_en    <= 1'b0;
            decode_en   <= 1'b0;
            execute_en  <= 1'b0;
            memory_en   <= 1'b0;
            wb_en       <= 1'b0;
            pc_en       <= 1'b0;
            mem_req     <= 1'b0;
            stat        <= STAT_AOK;
            halted      <= 1'b0;
            busy        <= 1'b0;
            cycle_count <= {CNT_W{1'b0}};
            instr_count <= {CNT_W{1'b0}};
        end else begin
            state_r    <= nxt_state_s;
            fetch_en   <= (nxt_state_s == ST_FETCH);
            decode_en  <= (nxt_state_s == ST_DECODE);
            execute_en <= (nxt_state_s == ST_EXECUTE);
            memory_en  <= (nxt_state_s == ST_MEMORY);
            wb_en      <= (nxt_state_s == ST_WRITEBACK);
            pc_en      <= (nxt_state_s == ST_PCUPD);
            mem_req    <= nxt_mem_req_s;
            stat       <= nxt_stat_s;
            halted     <= (nxt_state_s == ST_HALT);
            busy       <= nxt_busy_s;
            // busy is the registered view of the current state, so this counts
            // every executing cycle including one that faults
            if (busy && (cycle_count != CNT_MAX)) begin
                cycle_count <= cycle_count + CNT_ONE;
            end else begin
                cycle_count <= cycle_count;
            end
            if (retire_s && (instr_count != CNT_MAX)) begin
                instr_count <= instr_count + CNT_ONE;
            end else begin
                instr_count <= instr_count;
            end
        end
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_seq_stage_controller
// Self-checking bench. The driver plans each instruction from the stage rules
// (stage list, memory wait length, fault kind) and publishes, for every cycle,
// the outputs that must be visible; a compare process checks two DUT copies
// (32-bit and 4-bit counters) against that per-cycle expectation.
// -----------------------------------------------------------------------------
module tb_seq_stage_controller;

    localparam int MEMTO = 16;

    logic clk = 1'b0;
    logic rst, start, instr_valid, imem_error, mem_ready, dmem_error;
    logic [3:0] icode;
`ifdef SEQ_SINGLE_STEP_EN
    logic step;
`endif

    logic f_en, d_en, e_en_o, m_en, w_en, p_en, mreq, hlt, bsy;
    logic [2:0] st;
    logic [31:0] cyc32, ins32;
    logic f4, d4, x4, m4, w4, p4, mreq4, hlt4, bsy4;
    logic [2:0] st4;
    logic [3:0] cyc4, ins4;

    always #5 clk = ~clk;

    seq_stage_controller #(.CNT_W(32), .MEM_TIMEOUT(MEMTO)) dut (
        .clk(clk), .rst(rst),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .start(start), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .mem_ready(mem_ready), .dmem_error(dmem_error),
        .fetch_en(f_en), .decode_en(d_en), .execute_en(e_en_o), .memory_en(m_en),
        .wb_en(w_en), .pc_en(p_en), .mem_req(mreq), .stat(st), .halted(hlt),
        .busy(bsy), .cycle_count(cyc32), .instr_count(ins32)
    );

    seq_stage_controller #(.CNT_W(4), .MEM_TIMEOUT(MEMTO)) dut4 (
        .clk(clk), .rst(rst),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .start(start), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .mem_ready(mem_ready), .dmem_error(dmem_error),
        .fetch_en(f4), .decode_en(d4), .execute_en(x4), .memory_en(m4),
        .wb_en(w4), .pc_en(p4), .mem_req(mreq4), .stat(st4), .halted(hlt4),
        .busy(bsy4), .cycle_count(cyc4), .instr_count(ins4)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint satv(input longint v, input int w);
        longint mx;
        mx = (longint'(1) <<< w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit mem_instr(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
               (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    endfunction

    // ---------------- reference model state ----------------
    logic [2:0] m_stat;
    bit         m_halted;
    longint     m_cyc, m_ins;

    // expectation for the current cycle
    logic [5:0] x_en;
    logic       x_mreq, x_busy, x_halted;
    logic [2:0] x_stat;
    longint     x_cyc, x_ins;
    int         x_id = 0;
    int         seen_id = 0;

    // enable pulse monitors (plain counts of DUT activity)
    int mon_en [6];
    int mon_mreq;

    task automatic expect_cycle(input logic [5:0] en, input logic mr, input logic b);
        x_en = en; x_mreq = mr; x_busy = b;
        x_stat = m_stat; x_halted = m_halted; x_cyc = m_cyc; x_ins = m_ins;
        x_id++;
        if (b) m_cyc++;
    endtask

    // compare both DUT copies against the published expectation
    always @(negedge clk) begin
        if (x_id != seen_id) begin
            chk("enables",    {58'd0, f_en, d_en, e_en_o, m_en, w_en, p_en}, {58'd0, x_en});
            chk("mem_req",    {63'd0, mreq}, {63'd0, x_mreq});
            chk("stat",       {61'd0, st}, {61'd0, x_stat});
            chk("halted",     {63'd0, hlt}, {63'd0, x_halted});
            chk("busy",       {63'd0, bsy}, {63'd0, x_busy});
            chk("cycle_count", {32'd0, cyc32}, satv(x_cyc, 32));
            chk("instr_count", {32'd0, ins32}, satv(x_ins, 32));
            chk("enables4",   {57'd0, f4, d4, x4, m4, w4, p4, mreq4},
                              {57'd0, x_en, x_mreq});
            chk("status4",    {59'd0, st4, hlt4, bsy4}, {59'd0, x_stat, x_halted, x_busy});
            chk("cycle_count4", {60'd0, cyc4}, satv(x_cyc, 4));
            chk("instr_count4", {60'd0, ins4}, satv(x_ins, 4));
            seen_id <= x_id;
        end
    end

    // activity monitors
    always @(negedge clk) begin
        if (f_en)   mon_en[0]++;
        if (d_en)   mon_en[1]++;
        if (e_en_o) mon_en[2]++;
        if (m_en)   mon_en[3]++;
        if (w_en)   mon_en[4]++;
        if (p_en)   mon_en[5]++;
        if (mreq)   mon_mreq++;
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        start       = 1'($urandom);
        instr_valid = 1'($urandom);
        imem_error  = 1'($urandom);
        mem_ready   = 1'($urandom);
        dmem_error  = 1'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
        step        = 1'($urandom);
`endif
    endtask

    // assert rst in the current cycle; the next cycle shows reset values
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        m_stat = 3'd1; m_halted = 1'b0; m_cyc = 0; m_ins = 0;
        for (int k = 0; k < 6; k++) mon_en[k] = 0;
        mon_mreq = 0;
        expect_cycle(6'b000000, 1'b0, 1'b0);
    endtask

    task automatic start_run();
        tick();
        noise();
        start = 1'b1;
        expect_cycle(6'b000000, 1'b0, 1'b0);
    endtask

    task automatic halt_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            noise();
            expect_cycle(6'b000000, 1'b0, 1'b0);
        end
    endtask

    // fault: 0 none, 1 imem_error, 2 illegal icode; delay = cycles mem_ready low;
    // rst_at = MEMORY cycle in which rst is raised (-1 none).
    // outcome: 0 retired, 1 halted, 2 reset
    task automatic run_instr(input logic [3:0] ic, input int fault, input int delay,
                             input bit derr, input int rst_at, output int outcome);
        tick();
        noise();
        icode = ic;
        if (fault == 1) begin
            imem_error = 1'b1;
        end else if (fault == 2) begin
            imem_error = 1'b0; instr_valid = 1'b0;
        end else begin
            imem_error = 1'b0; instr_valid = 1'b1;
        end
        expect_cycle(6'b100000, 1'b0, 1'b1);
        if (fault != 0) begin
            m_stat = (fault == 1) ? 3'd3 : 3'd4;
            m_halted = 1'b1; outcome = 1;
            return;
        end
        if (ic == 4'h0) begin
            m_ins++; m_stat = 3'd2; m_halted = 1'b1; outcome = 1;
            return;
        end
        tick(); noise(); expect_cycle(6'b010000, 1'b0, 1'b1);
        tick(); noise(); expect_cycle(6'b001000, 1'b0, 1'b1);
        if (!mem_instr(ic)) begin
            tick(); noise(); expect_cycle(6'b000100, 1'b0, 1'b1);
            if (rst_at == 0) begin do_reset(); outcome = 2; return; end
        end else begin
            for (int i = 0; i < MEMTO; i++) begin
                tick(); noise();
                mem_ready = (i == delay);
                dmem_error = (i == delay) ? derr : 1'($urandom);
                expect_cycle(6'b000100, 1'b1, 1'b1);
                if (i == rst_at) begin do_reset(); outcome = 2; return; end
                if (i == delay) begin
                    if (derr) begin
                        m_stat = 3'd3; m_halted = 1'b1; outcome = 1;
                        return;
                    end
                    break;
                end
                if (i == MEMTO - 1) begin
                    m_stat = 3'd3; m_halted = 1'b1; outcome = 1;
                    return;
                end
            end
        end
        tick(); noise(); expect_cycle(6'b000010, 1'b0, 1'b1);
        tick(); noise(); expect_cycle(6'b000001, 1'b0, 1'b1);
        m_ins++;
`ifdef SEQ_SINGLE_STEP_EN
        for (int k = 0; k < 3; k++) begin
            tick(); noise();
            step = (k == 2);
            expect_cycle(6'b000000, 1'b0, 1'b0);
        end
`endif
        outcome = 0;
    endtask

    initial begin
        int oc;
        rst = 1'b1; start = 1'b0; icode = 4'h0; instr_valid = 1'b0;
        imem_error = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        do_reset();
        chk("reset_stat_lit", {61'd0, st}, 64'd1);

        // T1: OPq then halt
        start_run();
        run_instr(4'h6, 0, 0, 1'b0, -1, oc);
        run_instr(4'h0, 0, 0, 1'b0, -1, oc);
        halt_cycles(3);
        chk("t1_instr_lit", {32'd0, ins32}, 64'd2);
        chk("t1_stat_hlt_lit", {61'd0, st}, 64'd2);
        chk("t1_cycles_lit", {32'd0, cyc32}, 64'd7);
        chk("t1_wb_pc_lit", 64'(mon_en[4] + mon_en[5]), 64'd2);

        // T2: mrmovq, ready 3 cycles after MEMORY entry
        do_reset(); start_run();
        run_instr(4'h5, 0, 3, 1'b0, -1, oc);
        run_instr(4'h0, 0, 0, 1'b0, -1, oc);
        halt_cycles(2);
        chk("t2_mreq_cycles_lit", 64'(mon_mreq), 64'd4);
        chk("t2_cycles_lit", {32'd0, cyc32}, 64'd10);

        // T3: pushq, memory never ready -> timeout
        do_reset(); start_run();
        run_instr(4'hA, 0, 99, 1'b0, -1, oc);
        halt_cycles(3);
        chk("t3_mem_cycles_lit", 64'(mon_en[3]), 64'd16);
        chk("t3_stat_lit", {61'd0, st}, 64'd3);
        chk("t3_halted_lit", {63'd0, hlt}, 64'd1);
        chk("t3_wb_pc_lit", 64'(mon_en[4] + mon_en[5]), 64'd0);
        chk("t3_instr_lit", {32'd0, ins32}, 64'd0);

        // boundary: ready on the last permitted cycle wins
        do_reset(); start_run();
        run_instr(4'h8, 0, MEMTO - 1, 1'b0, -1, oc);
        run_instr(4'h0, 0, 0, 1'b0, -1, oc);
        halt_cycles(2);
        chk("ready_last_cycle_lit", {32'd0, ins32}, 64'd2);

        // T4: fetch faults
        do_reset(); start_run();
        run_instr(4'h6, 1, 0, 1'b0, -1, oc);
        halt_cycles(2);
        chk("t4_imem_lit", {61'd0, st}, 64'd3);
        do_reset(); start_run();
        run_instr(4'h6, 2, 0, 1'b0, -1, oc);
        halt_cycles(2);
        chk("t4_ins_lit", {61'd0, st}, 64'd4);

        // T5: reset during MEMORY with mem_req high
        do_reset(); start_run();
        run_instr(4'h5, 0, 10, 1'b0, 2, oc);
        chk("t5_mreq_lit", {62'd0, mreq, bsy}, 64'd0);
        start_run();
        run_instr(4'h1, 0, 0, 1'b0, -1, oc);
        run_instr(4'h0, 0, 0, 1'b0, -1, oc);
        halt_cycles(2);
        chk("t5_rerun_lit", {32'd0, ins32}, 64'd2);

        // T6: counter saturation on the 4-bit copy
        do_reset(); start_run();
        for (int k = 0; k < 20; k++) run_instr(4'h6, 0, 0, 1'b0, -1, oc);
        run_instr(4'h0, 0, 0, 1'b0, -1, oc);
        halt_cycles(2);
        chk("t6_instr4_lit", {60'd0, ins4}, 64'd15);
        chk("t6_instr32_lit", {32'd0, ins32}, 64'd21);

        // randomized programs
        for (int t = 0; t < 12; t++) begin
            do_reset(); start_run();
            oc = 0;
            for (int k = 0; k < 15 && oc == 0; k++) begin
                int r, dly, flt, rat;
                bit de;
                r   = int'($urandom_range(0, 99));
                dly = (r < 5) ? MEMTO - 1 : (r < 8) ? MEMTO : int'($urandom_range(0, 4));
                de  = ($urandom_range(0, 19) == 0);
                flt = (r >= 97) ? int'($urandom_range(1, 2)) : 0;
                rat = (r >= 94 && r < 97) ? int'($urandom_range(0, 2)) : -1;
                run_instr(4'($urandom_range(1, 11)), flt, dly, de, rat, oc);
            end
            if (oc == 0) run_instr(4'h0, 0, 0, 1'b0, -1, oc);
            if (oc == 1) halt_cycles(3);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
